// File: rtl/code_pipe_bist_pkg.sv
// code_pipe_bist_pkg: shared state enum and code/signature helpers sized for the widest W (6)
package code_pipe_bist_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;
  localparam int W_MAX = 6;
  localparam int N_MAX = 64;
  function automatic logic [N_MAX-1:0] onehot_decode(input logic [W_MAX-1:0] code);
    return 64'd1 << code;
  endfunction
  function automatic logic [W_MAX-1:0] priority_encode(input logic [N_MAX-1:0] oh);
    logic [W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_MAX; i++) if (oh[i]) r = W_MAX'(i);
    return r;
  endfunction
  // rotate-left within the low w bits, then fold in d
  function automatic logic [W_MAX-1:0] sig_update(input logic [W_MAX-1:0] sig, input logic [W_MAX-1:0] d, input int w);
    logic [W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < W_MAX; i++) if (i < w) r[i] = sig[(i + w - 1) % w] ^ d[i];
    return r;
  endfunction
endpackage

// File: rtl/code_pipe_bist_ctrl.sv
// code_pipe_bist_ctrl: BIST sequencer with pattern counter, result checker and signature
module code_pipe_bist_ctrl
  import code_pipe_bist_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bist_start,
  input  logic         s1_valid,
  input  logic         s2_valid,
  input  logic [W-1:0] s2_data,
  input  logic [W-1:0] s2_tag,
  output state_t       state,
  output logic [W-1:0] cnt,
  output logic         inject,
  output logic         bist_mode,
  output logic         normal,
  output logic         bist_busy,
  output logic         bist_done,
  output logic         bist_fail,
  output logic [W-1:0] bist_sig
);
  state_t nxt;
  logic dcnt;
  logic [W_MAX-1:0] sig6, d6, upd;
  logic unused;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = bist_start ? FLUSH : state;
      FLUSH:      nxt = (s1_valid | s2_valid) ? FLUSH : RUN;
      RUN:        nxt = (cnt == '1) ? DRAIN : RUN;
      DRAIN:      nxt = dcnt ? DONE : DRAIN;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    sig6 = '0;
    sig6[W-1:0] = bist_sig;
    d6 = '0;
    d6[W-1:0] = s2_data;
    upd = sig_update(sig6, d6, W);
  end
  assign unused    = ^upd;
  assign inject    = state == RUN;
  assign bist_mode = state == RUN || state == DRAIN;
  assign normal    = state == IDLE || state == DONE;
  assign bist_busy = state == FLUSH || bist_mode;
  assign bist_done = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      dcnt      <= 1'b0;
      bist_sig  <= '0;
      bist_fail <= 1'b0;
    end else begin
      cnt  <= inject ? cnt + 1'b1 : '0;
      dcnt <= (state == DRAIN) & !dcnt;
      if (state == FLUSH && nxt == RUN) begin
        bist_sig  <= '0;
        bist_fail <= 1'b0;
      end else if (bist_mode && s2_valid) begin
        bist_fail <= bist_fail | (s2_data != s2_tag);
        bist_sig  <= upd[W-1:0];
      end
    end
  end
endmodule

// File: rtl/code_pipe_bist.sv
// code_pipe_bist: one-hot decode / priority re-encode pipeline (depth 2) with on-chip BIST
module code_pipe_bist
  import code_pipe_bist_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [W-1:0] fault_mask,
  input  logic         bist_start,
  output logic         bist_busy,
  output logic         bist_done,
  output logic         bist_fail,
  output logic [W-1:0] bist_sig
);
  localparam int N = 1 << W;
  state_t state;
  logic [N-1:0] s1_oh;
  logic [W-1:0] s1_tag, s2_data, s2_tag, cnt, code;
  logic s1_valid, s2_valid, s1_en, s2_en, inject, bist_mode, normal;
  logic [W_MAX-1:0] code6, enc6;
  logic [N_MAX-1:0] oh64, s1_oh64;
  logic unused;
  code_pipe_bist_ctrl #(.W(W)) u_ctrl (
    .clk(clk), .reset(reset), .bist_start(bist_start),
    .s1_valid(s1_valid), .s2_valid(s2_valid), .s2_data(s2_data), .s2_tag(s2_tag),
    .state(state), .cnt(cnt), .inject(inject), .bist_mode(bist_mode), .normal(normal),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail), .bist_sig(bist_sig)
  );
  always_comb begin
    code = inject ? cnt : data_in;
    code6 = '0;
    code6[W-1:0] = code;
    oh64 = onehot_decode(code6);
    s1_oh64 = '0;
    s1_oh64[N-1:0] = s1_oh;
    enc6 = priority_encode(s1_oh64);
  end
  assign unused    = ^{oh64, enc6, state};
  assign s2_en     = bist_mode | !s2_valid | out_ready;
  assign s1_en     = !s1_valid | s2_en;
  // reset gating keeps every output low while reset is held
  assign in_ready  = reset & normal & s1_en;
  assign out_valid = s2_valid & !bist_mode;
  assign data_out  = s2_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_oh    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= inject | (in_valid & in_ready);
        s1_oh    <= oh64[N-1:0];
        s1_tag   <= code;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        s2_data  <= enc6[W-1:0] ^ fault_mask;
        s2_tag   <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_code_pipe_bist.sv
// tb_code_pipe_bist: scoreboard bench for the code pipeline and its BIST controller
module tb_code_pipe_bist;
  import code_pipe_bist_pkg::*;
  localparam int W = 5;
  localparam int N = 32;
  logic clk = 0, reset = 0;
  logic [W-1:0] data_in = '0, data_out, fault_mask = '0, bist_sig;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, bist_start = 0;
  logic bist_busy, bist_done, bist_fail;
  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$], got_q[$];

  code_pipe_bist #(.W(W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .fault_mask(fault_mask),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_fail(bist_fail), .bist_sig(bist_sig)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] c, input logic [W-1:0] m);
    logic [W_MAX-1:0] c6, e;
    c6 = '0;
    c6[W-1:0] = c;
    e = priority_encode(onehot_decode(c6));
    return e[W-1:0] ^ m;
  endfunction

  task automatic tick;
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(data_in, fault_mask));
    if (out_valid && out_ready) got_q.push_back(data_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      data_in = W'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      fault_mask = W'($urandom); bist_start = 1'($urandom);
      @(posedge clk); #3;
      checks++;
      if ({in_ready, out_valid, data_out, bist_busy, bist_done, bist_fail, bist_sig} !== '0) begin
        failures++;
        $display("FAIL reset_hold: outputs=%b required all zero",
                 {in_ready, out_valid, data_out, bist_busy, bist_done, bist_fail, bist_sig});
      end
    end
    data_in = '0; in_valid = 0; out_ready = 0; fault_mask = '0; bist_start = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_stream;
    int first_out = -1, last_out = -1, n_out = 0, cyc = 0;
    exp_q.delete(); got_q.delete();
    out_ready = 1; fault_mask = '0;
    while (n_out < N && cyc < 80) begin
      in_valid = cyc < N;
      data_in = W'(cyc);
      #1;
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      tick;
      cyc++;
    end
    in_valid = 0;
    checks++;
    if (first_out !== 2) begin
      failures++;
      $display("FAIL stream_latency: first out_valid cycle=%0d required 2", first_out);
    end
    checks++;
    if (n_out !== N || last_out - first_out !== N - 1) begin
      failures++;
      $display("FAIL stream_bubbles: outputs=%0d span=%0d required %0d %0d", n_out, last_out - first_out, N, N - 1);
    end
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] g, e;
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++;
      if (g !== W'(i) || g !== e) begin
        failures++;
        $display("FAIL stream_data[%0d]: got %0d required %0d (model %0d)", i, g, i, e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic acc;
    int n = 0;
    logic [W-1:0] want [3];
    want[0] = 5; want[1] = 9; want[2] = 12;
    exp_q.delete(); got_q.delete();
    out_ready = 0;
    in_valid = 1; data_in = 5; tick;
    data_in = 9; tick;
    data_in = 12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 5) begin
        failures++;
        $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b data_out=%0d required 0 1 5", i, in_ready, out_valid, data_out);
      end
      tick;
    end
    out_ready = 1;
    while (got_q.size() < 3 && n < 20) begin
      #1;
      acc = in_valid && in_ready;
      tick;
      if (acc) in_valid = 0;
      n++;
    end
    in_valid = 0;
    repeat (3) tick;
    checks++;
    if (got_q.size() !== 3 || exp_q.size() !== 3) begin
      failures++;
      $display("FAIL bp_count: outputs=%0d expected_entries=%0d required 3 3", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] g, e;
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++;
      if (g !== want[i] || g !== e) begin
        failures++;
        $display("FAIL bp_data[%0d]: got %0d required %0d (model %0d)", i, g, want[i], e);
      end
    end
  endtask

  task automatic test_fault;
    int n = 0;
    logic [W-1:0] g, e;
    exp_q.delete(); got_q.delete();
    out_ready = 1; fault_mask = 5'b00100;
    in_valid = 1; data_in = 3; tick;
    in_valid = 0;
    while (got_q.size() < 1 && n < 10) begin tick; n++; end
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (g !== 7 || g !== e) begin
      failures++;
      $display("FAIL fault_inject: got %0d required 7 (model %0d)", g, e);
    end
    fault_mask = '0;
    tick;
  endtask

  task automatic test_bist(input logic [W-1:0] mask, input logic exp_fail);
    int n = 0, outs = 0, ir = 0;
    logic [W_MAX-1:0] s, d;
    s = '0;
    for (int c = 0; c < N; c++) begin
      d = '0;
      d[W-1:0] = model(W'(c), mask);
      s = sig_update(s, d, W);
    end
    got_q.delete(); exp_q.delete();
    fault_mask = mask; in_valid = 0; out_ready = 1;
    bist_start = 1; tick; bist_start = 0;
    while (bist_busy && n < 200) begin
      if (out_valid) outs++;
      if (in_ready) ir++;
      n++;
      tick;
    end
    checks++;
    if (n !== 1 + N + 2) begin
      failures++;
      $display("FAIL bist_length: busy cycles=%0d required %0d", n, 1 + N + 2);
    end
    checks++;
    if (outs !== 0 || ir !== 0) begin
      failures++;
      $display("FAIL bist_quiet: out_valid cycles=%0d in_ready cycles=%0d required 0 0", outs, ir);
    end
    checks++;
    if (bist_done !== 1'b1 || bist_fail !== exp_fail) begin
      failures++;
      $display("FAIL bist_status: done=%b fail=%b required 1 %b", bist_done, bist_fail, exp_fail);
    end
    checks++;
    if (bist_sig !== s[W-1:0]) begin
      failures++;
      $display("FAIL bist_sig: got %h required %h", bist_sig, s[W-1:0]);
    end
    repeat (2) tick;
    checks++;
    if (bist_done !== 1'b1 || in_ready !== 1'b1 || bist_sig !== s[W-1:0]) begin
      failures++;
      $display("FAIL bist_hold: done=%b in_ready=%b sig=%h required 1 1 %h", bist_done, in_ready, bist_sig, s[W-1:0]);
    end
    fault_mask = '0;
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1; in_valid = 0;
    bist_start = 1; tick; bist_start = 0;
    repeat (11) tick;
    checks++;
    if (bist_busy !== 1'b1 || dut.u_ctrl.state !== RUN) begin
      failures++;
      $display("FAIL midrun_setup: busy=%b state=%0d required 1 %0d", bist_busy, dut.u_ctrl.state, RUN);
    end
    reset = 0;
    #2;
    checks++;
    if (dut.u_ctrl.state !== IDLE || bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_fail !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: state=%0d busy=%b done=%b fail=%b out_valid=%b required IDLE 0 0 0 0",
               dut.u_ctrl.state, bist_busy, bist_done, bist_fail, out_valid);
    end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    test_bist('0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_fault;
    test_bist('0, 1'b0);
    test_bist(5'b00001, 1'b1);
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/code_pipe_bist.md
# code_pipe_bist

Parametrised decode/re-encode datapath with built-in self-test for the DFT test chip. Each W-bit code is one-hot decoded into a 2^W-bit register stage, then priority-encoded back to W bits through a fault-injection XOR into an output stage, giving a valid/ready pipeline of depth 2. An on-chip BIST controller drives all 2^W codes through the same pipeline. It checks every result against the code that was sent and compacts the results into a signature.

## Interface
- W, default 5: code width; one-hot width N = 2^W (W from 2 to 6)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state clears while low
- data_in  in  W  input code
- in_valid  in  1  data_in is valid
- in_ready  out  1  stage 1 can accept data
- data_out  out  W  result code
- out_valid  out  1  data_out is valid
- out_ready  in  1  consumer accepts data_out
- fault_mask  in  W  XOR applied at the stage-2 input in all modes; 0 in normal use
- bist_start  in  1  one-cycle pulse; accepted in IDLE or DONE only
- bist_busy  out  1  FSM is in FLUSH, RUN or DRAIN
- bist_done  out  1  FSM is in DONE
- bist_fail  out  1  sticky: at least one BIST mismatch in the last run
- bist_sig  out  W  signature from the last run

## Operation
- Stage 1 registers: s1_oh (N bits, one-hot of the accepted code), s1_tag (W bits, the accepted code), s1_valid.
- Stage 2 registers:
  - s2_data = priority_encode(s1_oh) ^ fault_mask, where the highest set bit wins and all-zero encodes to 0.
  - s2_tag = s1_tag.
  - s2_valid.
  - data_out is s2_data; out_valid is s2_valid outside BIST.
- Advance rules:
  - s2_en = !s2_valid | out_ready; in BIST states s2_en = 1.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en & (state == IDLE or DONE).
- Stage 1 source: in_valid & in_ready in normal mode; the pattern counter cnt in RUN.
- FSM states and transitions:
  - IDLE: bist_start goes to FLUSH.
  - FLUSH: in_ready = 0; normal items drain using out_ready. When s1_valid = s2_valid = 0, go to RUN. On entry to RUN, clear cnt, bist_sig and bist_fail.
  - RUN: inject cnt with valid = 1 every cycle, then cnt++. After injecting cnt = N-1, go to DRAIN.
  - DRAIN: 2 cycles with no injection, then go to DONE.
  - DONE: holds the results. bist_start goes to FLUSH; otherwise stay.
- Checking and signature: in RUN and DRAIN, while s2_valid:
  - bist_fail |= (s2_data != s2_tag).
  - bist_sig = {bist_sig[W-2:0], bist_sig[W-1]} ^ s2_data.
- out_valid is forced to 0 in RUN and DRAIN, and out_ready is ignored there.
- bist_start in FLUSH, RUN or DRAIN is ignored.
- in_valid is ignored while in_ready = 0.

## Timing
- Reset values: in_ready 1 after reset releases, with all other outputs 0 (data_out, out_valid, bist_busy, bist_done, bist_fail, bist_sig); state is IDLE.
- Latency: data accepted at edge k appears as out_valid/data_out after edge k+1, i.e. 2 register stages.
- Throughput is 1 code per cycle with out_ready held at 1.
- data_out stays stable while out_valid & !out_ready.
- in_ready is combinational from out_ready.
- When both stages are full and out_ready = 0, in_ready = 0.
- BIST run length:
  - FLUSH lasts at least 1 cycle.
  - RUN lasts exactly N cycles.
  - DRAIN lasts 2 cycles.
  - bist_done rises on the edge after the last DRAIN cycle.
- The final N-th check and signature update happen in the last DRAIN cycle.
- A reset assertion at any time, including mid-RUN, clears the pipeline and all BIST outputs immediately.

## Structure
- Shared package holds the FSM state enum (IDLE, FLUSH, RUN, DRAIN, DONE), the onehot_decode and priority_encode functions, and the signature-update function. The bench model also uses these functions.
- Sub-module code_pipe_bist_ctrl: FSM, cnt, bist_fail and bist_sig. The parent holds the two pipeline stages and the source mux.

## Test plan
- Reset: hold reset low with random inputs -> all outputs 0; after release, in_ready = 1 and out_valid = 0.
- Stream, W=5: codes 0..31 back to back with out_ready = 1 and fault_mask = 0 -> data_out 0..31 in order, first out_valid 2 cycles after the first accept, no bubbles.
- Backpressure: accept 5 and 9, then hold out_ready = 0 -> in_ready = 0 and data_out stays 5. Release -> 5 then 9, then accepts resume, with nothing lost or duplicated.
- Fault injection: fault_mask = 5'b00100 with input 3 -> data_out 7.
- BIST, fault_mask = 0, W=5: pulse bist_start in IDLE -> bist_busy for 1 + 32 + 2 cycles, then bist_done = 1, bist_fail = 0, and bist_sig equal to the package model. Repeat with fault_mask = 1 -> bist_fail = 1.
- Reset mid-RUN: assert reset at cnt = 10 -> state IDLE, with bist_busy, bist_done and bist_fail all 0. A following bist_start runs a full clean pass.
